io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder.sv | 160 ++++++++++++++++
 tb/tb_io_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: memory-mapped board I/O block (keys, switches, HEX, LEDs)
// with a single-cycle ack bus, key-press edge capture and a maskable level
// interrupt. Define IO_KEY_DEBOUNCE_EN to add per-key debounce counters.
// Without it, the synchronized keys are used directly.
module io_responder #(
  parameter int          DBITS      = 16,
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  output logic             ack,
  output logic [DBITS-1:0] rdata,
  input  logic [3:0]       key_in,
  input  logic [9:0]       sw_in,
  output logic [15:0]      hex_out,
  output logic [9:0]       ledr_out,
  output logic [7:0]       ledg_out,
  output logic             irq
);

  localparam logic [DBITS-1:0] A_KEY   = DBITS'(16'hFFF0);
  localparam logic [DBITS-1:0] A_SW    = DBITS'(16'hFFF2);
  localparam logic [DBITS-1:0] A_KEDGE = DBITS'(16'hFFF4);
  localparam logic [DBITS-1:0] A_KMASK = DBITS'(16'hFFF6);
  localparam logic [DBITS-1:0] A_HEX   = DBITS'(16'hFFF8);
  localparam logic [DBITS-1:0] A_LEDR  = DBITS'(16'hFFFA);
  localparam logic [DBITS-1:0] A_LEDG  = DBITS'(16'hFFFC);

  logic             ack_q, ack_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic [15:0]      hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;
  logic [3:0]       kedge_q, kedge_d;
  logic [3:0]       kmask_q, kmask_d;
  logic             irq_q, irq_d;
  logic [3:0]       key_s1_q, key_s2_q;
  logic [9:0]       sw_s1_q, sw_s2_q;
  logic [3:0]       key_deb;      // current debounced key level
  logic [3:0]       key_deb_nxt;  // debounced key level after this edge
  logic [DBITS-1:0] rd_val;
  logic             wr;

`ifdef IO_KEY_DEBOUNCE_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [3:0]  key_deb_q, key_deb_d;

  // Per-key stability counter: restarts whenever the synced key agrees with
  // the debounced level, saturates at the window end where the level flips.
  always_comb begin
    key_deb_d = key_deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (key_s2_q[i] == key_deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= DEB_CYCLES - 16'd1) begin
        key_deb_d[i] = key_s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Debounce state registers; keys idle high (released) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_deb_q <= 4'hF;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      key_deb_q <= key_deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_deb     = key_deb_q;
  assign key_deb_nxt = key_deb_d;
`else
  // The synced key is the debounced key; DEB_CYCLES has no effect here and
  // is only referenced so the parameter remains part of the interface.
  if (DEB_CYCLES == 16'd0) begin : g_deb_window_unused
  end
  assign key_deb     = key_s2_q;
  assign key_deb_nxt = key_s1_q;
`endif

  // Read mux over the register map; unmapped addresses read as DEAD.
  always_comb begin
    rd_val = DBITS'(16'hDEAD);
    case (addr)
      A_KEY:   rd_val = DBITS'(key_deb);
      A_SW:    rd_val = DBITS'(sw_s2_q);
      A_KEDGE: rd_val = DBITS'(kedge_q);
      A_KMASK: rd_val = DBITS'(kmask_q);
      A_HEX:   rd_val = DBITS'(hex_q);
      A_LEDR:  rd_val = DBITS'(ledr_q);
      A_LEDG:  rd_val = DBITS'(ledg_q);
      default: rd_val = DBITS'(16'hDEAD);
    endcase
  end

  // Next-state: bus response, register writes, edge capture and interrupt.
  always_comb begin
    wr      = req & we;
    ack_d   = req;
    rdata_d = (req && !we) ? rd_val : '0;
    hex_d   = (wr && addr == A_HEX)   ? wdata[15:0] : hex_q;
    ledr_d  = (wr && addr == A_LEDR)  ? wdata[9:0]  : ledr_q;
    ledg_d  = (wr && addr == A_LEDG)  ? wdata[7:0]  : ledg_q;
    kmask_d = (wr && addr == A_KMASK) ? wdata[3:0]  : kmask_q;
    kedge_d = kedge_q;
    if (wr && addr == A_KEDGE) kedge_d = kedge_d & ~wdata[3:0];
    // A press on the same edge as a clear must survive, so set goes last.
    kedge_d = kedge_d | (key_deb & ~key_deb_nxt);
    irq_d   = |(kedge_q & kmask_q);
  end

  // State registers; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      hex_q    <= '0;
      ledr_q   <= '0;
      ledg_q   <= '0;
      kedge_q  <= '0;
      kmask_q  <= '0;
      irq_q    <= 1'b0;
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      hex_q    <= hex_d;
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      kedge_q  <= kedge_d;
      kmask_q  <= kmask_d;
      irq_q    <= irq_d;
      key_s1_q <= key_in;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw_in;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign hex_out  = hex_q;
  assign ledr_out = ledr_q;
  assign ledg_out = ledg_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_io_responder.sv
// Testbench for io_responder: directed scenarios plus randomized bus and key
// traffic, checked every cycle against a register-level reference model.
module tb_io_responder;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        ack;
  logic [15:0] rdata;
  logic [3:0]  key_in = 4'hF;
  logic [9:0]  sw_in = '0;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;
  logic [7:0]  ledg_out;
  logic        irq;

  always #5 clk = ~clk;

  io_responder #(.DBITS(16), .DEB_CYCLES(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .key_in(key_in),
    .sw_in(sw_in), .hex_out(hex_out), .ledr_out(ledr_out),
    .ledg_out(ledg_out), .irq(irq)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: architectural register contents plus key history.
  logic        m_ack;
  logic [15:0] m_rdata, m_hex;
  logic [9:0]  m_ledr, m_sw1, m_sw2;
  logic [7:0]  m_ledg;
  logic [3:0]  m_kedge, m_kmask, m_ks1, m_ks2, m_deb;
  logic        m_irq;
  int          m_run [4];  // consecutive cycles the synced key disagreed with m_deb

  task automatic model_reset();
    m_ack = 0; m_rdata = 0; m_hex = 0; m_ledr = 0; m_ledg = 0;
    m_kedge = 0; m_kmask = 0; m_irq = 0;
    m_ks1 = 4'hF; m_ks2 = 4'hF; m_deb = 4'hF; m_sw1 = 0; m_sw2 = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a)
      16'hFFF0: return {12'b0, m_deb};
      16'hFFF2: return {6'b0, m_sw2};
      16'hFFF4: return {12'b0, m_kedge};
      16'hFFF6: return {12'b0, m_kmask};
      16'hFFF8: return m_hex;
      16'hFFFA: return {6'b0, m_ledr};
      16'hFFFC: return {8'b0, m_ledg};
      default:  return 16'hDEAD;
    endcase
  endfunction

  // Keys whose debounced level will fall (a press) at the coming edge.
  function automatic logic [3:0] press_next();
    logic [3:0] p;
    p = '0;
`ifdef IO_KEY_DEBOUNCE_EN
    for (int i = 0; i < 4; i++)
      p[i] = m_deb[i] && !m_ks2[i] && (m_run[i] + 1 == DEB);
`else
    p = m_deb & ~m_ks1;
`endif
    return p;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    logic [3:0] nd;
    logic [3:0] clr;
    logic       w;
    w = req && we;
    m_rdata = (req && !we) ? m_read(addr) : 16'h0;
    m_ack = req;
    nd = m_deb;
`ifdef IO_KEY_DEBOUNCE_EN
    for (int i = 0; i < 4; i++) begin
      if (m_ks2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin nd[i] = m_ks2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
`else
    nd = m_ks1;
`endif
    m_irq = |(m_kedge & m_kmask);
    clr = (w && addr == 16'hFFF4) ? wdata[3:0] : 4'h0;
    m_kedge = (m_kedge & ~clr) | (m_deb & ~nd);
    if (w && addr == 16'hFFF6) m_kmask = wdata[3:0];
    if (w && addr == 16'hFFF8) m_hex = wdata;
    if (w && addr == 16'hFFFA) m_ledr = wdata[9:0];
    if (w && addr == 16'hFFFC) m_ledg = wdata[7:0];
    m_deb = nd;
    m_ks2 = m_ks1; m_ks1 = key_in;
    m_sw2 = m_sw1; m_sw1 = sw_in;
  endtask

  // One clock: model update at the edge, DUT outputs compared just after.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", ack, m_ack);
    chk("rdata", rdata, m_rdata);
    chk("hex", hex_out, m_hex);
    chk("ledr", ledr_out, m_ledr);
    chk("ledg", ledg_out, m_ledg);
    chk("irq", irq, m_irq);
  endtask

  task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d);
    req = 1; we = w; addr = a; wdata = d;
    step();
    req = 0; we = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_hex"}, hex_out, 0);
    chk({tag, "_ledr"}, ledr_out, 0);
    chk({tag, "_ledg"}, ledg_out, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask

  logic [3:0] exp_short;
  bit         found;

  initial begin
    model_reset();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;

    // Reset contents of read-only and control registers.
    xfer(0, 16'hFFF0, 0); chk("rst_key", rdata, 16'h000F);
    xfer(0, 16'hFFF4, 0); chk("rst_kedge", rdata, 16'h0000);
    xfer(0, 16'hFFF6, 0); chk("rst_kmask", rdata, 16'h0000);

    // HEX write then read-back.
    xfer(1, 16'hFFF8, 16'h1234); chk("hex_wr", hex_out, 16'h1234);
    xfer(0, 16'hFFF8, 0);
    chk("hex_rd_ack", ack, 1); chk("hex_rd", rdata, 16'h1234);

    // Back-to-back writes; upper bits discarded.
    xfer(1, 16'hFFFA, 16'hFFFF); chk("b2b_ack1", ack, 1);
    xfer(1, 16'hFFFC, 16'hABCD); chk("b2b_ack2", ack, 1);
    chk("ledr_val", ledr_out, 10'h3FF); chk("ledg_val", ledg_out, 8'hCD);
    step(); chk("b2b_ack_drop", ack, 0); chk("idle_rdata", rdata, 0);

    // Unmapped read and ignored write to a read-only register.
    xfer(0, 16'hFFEE, 0); chk("unmapped", rdata, 16'hDEAD);
    xfer(1, 16'hFFF0, 16'h0000);
    xfer(0, 16'hFFF0, 0); chk("key_ro", rdata, 16'h000F);
    sw_in = 10'h2A5; repeat (3) step();
    xfer(0, 16'hFFF2, 0); chk("sw_rd", rdata, 16'h02A5);

    // Short glitch on key 2, then a held press.
`ifdef IO_KEY_DEBOUNCE_EN
    exp_short = 4'h0;
`else
    exp_short = 4'h4;
`endif
    key_in = 4'b1011; repeat (3) step();
    key_in = 4'hF;    repeat (8) step();
    xfer(0, 16'hFFF4, 0); chk("kedge_glitch", rdata, {12'b0, exp_short});
    xfer(1, 16'hFFF4, 16'h000F);
    key_in = 4'b1011; repeat (10) step();
    xfer(0, 16'hFFF4, 0); chk("kedge_press", rdata, 16'h0004);
    xfer(1, 16'hFFF6, 16'h0004);
    step(); step(); chk("irq_set", irq, 1);
    key_in = 4'hF; repeat (8) step();
    xfer(0, 16'hFFF4, 0); chk("release_no_edge", rdata, 16'h0004);

    // Clear racing a new press of key 1: the set must win.
    xfer(1, 16'hFFF4, 16'h000F);
    xfer(1, 16'hFFF6, 16'h0002);
    key_in = 4'b1101; repeat (10) step();
    key_in = 4'hF;    repeat (10) step();
    xfer(0, 16'hFFF4, 0); chk("k1_first", rdata, 16'h0002);
    key_in = 4'b1101;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (press_next()[1]) begin
        found = 1;
        xfer(1, 16'hFFF4, 16'h0002);
      end else step();
    end
    chk("k1_press_seen", found, 1);
    xfer(0, 16'hFFF4, 0); chk("set_wins", rdata[1], 1);
    chk("irq_before_clr", irq, 1);
    xfer(1, 16'hFFF4, 16'h0002);
    step(); chk("irq_drop", irq, 0);
    xfer(0, 16'hFFF4, 0); chk("k1_cleared", rdata, 16'h0000);
    key_in = 4'hF; repeat (10) step();

    // Reset arriving while a write is pending.
    req = 1; we = 1; addr = 16'hFFF8; wdata = 16'h5555;
    #2 rst_n = 0;
    model_reset();
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    req = 0; we = 0;
    @(negedge clk) rst_n = 1;
    step(); chk("midrst_noack", ack, 0); chk("midrst_hex", hex_out, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        7:       addr = 16'hFFEE;
        8:       addr = 16'hFFF1;
        9:       addr = 16'($urandom);
        default: addr = 16'hFFF0 + 16'(2 * $urandom_range(0, 6));
      endcase
      wdata = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) key_in[k] = ~key_in[k];
      if ($urandom_range(0, 31) == 0) sw_in = 10'($urandom);
      step();
    end
    req = 0; we = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
